// File: rtl/mat_mult_1632_mem_if.sv
// Signal bundle joining the 16x49 * 49x32 multiplier memory bridge to its host
// and to the multiplier core. The bridge takes the slave view.
interface mat_mult_1632_mem_if;
    logic               host_we;
    logic               host_sel;
    logic [10:0]        host_addr;
    logic signed [15:0] host_wdata;
    logic               host_go;
    logic               mult_start;

    logic [9:0]         addr_a;
    logic signed [15:0] data_a;
    logic [10:0]        addr_b;
    logic signed [15:0] data_b;
    logic [8:0]         addr_c;
    logic signed [31:0] data_c;
    logic               we_c;
    logic               mult_done;

    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;
    logic [8:0]         out_addr;
    logic               out_last;
    logic               busy;
    logic               err_cnt;
    logic               err_wr;

    modport slave (
        input  host_we, host_sel, host_addr, host_wdata, host_go,
        input  addr_a, addr_b, addr_c, data_c, we_c, mult_done, out_ready,
        output mult_start, data_a, data_b,
        output out_valid, out_data, out_addr, out_last, busy, err_cnt, err_wr
    );

    modport master (
        output host_we, host_sel, host_addr, host_wdata, host_go,
        output addr_a, addr_b, addr_c, data_c, we_c, mult_done, out_ready,
        input  mult_start, data_a, data_b,
        input  out_valid, out_data, out_addr, out_last, busy, err_cnt, err_wr
    );
endinterface

// File: rtl/mat_mult_1632_mem.sv
// Operand/result memory and host bridge for the 16x49 * 49x32 multiplier:
// host loads A/B, launches the core, captures C writes, then streams C back.
module mat_mult_1632_mem #(
    parameter int A_DEPTH = 784,
    parameter int B_DEPTH = 1568,
    parameter int C_DEPTH = 512
) (
    input  logic               clk,
    input  logic               reset,
    mat_mult_1632_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

    localparam logic [8:0] C_LAST  = 9'(C_DEPTH - 1);
    localparam logic [9:0] C_COUNT = 10'(C_DEPTH);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    logic signed [15:0] mem_a [A_DEPTH];
    logic signed [15:0] mem_b [B_DEPTH];
    logic signed [31:0] mem_c [C_DEPTH];

    state_e     state_q;
    logic       mult_start_q;
    logic       err_cnt_q;
    logic       err_wr_q;
    logic [9:0] wr_cnt_q, wr_cnt_d;
    logic [8:0] rd_ptr_q;

    logic host_wr_a, host_wr_b, c_wr;
    logic rd_a_ok, rd_b_ok;

    assign host_wr_a = (state_q == IDLE) && bus.host_we && !bus.host_sel
                       && (32'(bus.host_addr) < A_DEPTH);
    assign host_wr_b = (state_q == IDLE) && bus.host_we && bus.host_sel
                       && (32'(bus.host_addr) < B_DEPTH);
    assign c_wr      = (state_q == BUSY) && bus.we_c;

    assign rd_a_ok = 32'(bus.addr_a) < A_DEPTH;
    assign rd_b_ok = 32'(bus.addr_b) < B_DEPTH;

    // NOTE: memory arrays carry no reset so they map onto RAM and keep their
    // contents across a reset; only the control state is reset.
    always_ff @(posedge clk) begin
        if (host_wr_a) mem_a[bus.host_addr[9:0]] <= bus.host_wdata;
        if (host_wr_b) mem_b[bus.host_addr]      <= bus.host_wdata;
        if (c_wr)      mem_c[bus.addr_c]         <= bus.data_c;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (c_wr && (wr_cnt_q != CNT_MAX)) wr_cnt_d = wr_cnt_q + 10'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mult_start_q <= 1'b0;
            wr_cnt_q     <= '0;
            rd_ptr_q     <= '0;
            err_cnt_q    <= 1'b0;
            err_wr_q     <= 1'b0;
        end else begin
            mult_start_q <= 1'b0;
            wr_cnt_q     <= wr_cnt_d;
            case (state_q)
                IDLE: begin
                    if (bus.host_go) begin
                        mult_start_q <= 1'b1;
                        wr_cnt_q     <= '0;
                        err_cnt_q    <= 1'b0;
                        err_wr_q     <= 1'b0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.host_we) err_wr_q <= 1'b1;
                    // wr_cnt_d already includes a C write landing with done
                    if (bus.mult_done) begin
                        rd_ptr_q <= '0;
                        state_q  <= DRAIN;
                        if (wr_cnt_d != C_COUNT) err_cnt_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.host_we) err_wr_q <= 1'b1;
                    if (bus.out_ready) begin
                        if (rd_ptr_q == C_LAST) begin
                            rd_ptr_q <= '0;
                            state_q  <= IDLE;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 9'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_a     = rd_a_ok ? mem_a[bus.addr_a] : '0;
    assign bus.data_b     = rd_b_ok ? mem_b[bus.addr_b] : '0;
    assign bus.mult_start = mult_start_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_valid  = (state_q == DRAIN);
    assign bus.out_last   = (state_q == DRAIN) && (rd_ptr_q == C_LAST);
    assign bus.out_data   = mem_c[rd_ptr_q];
    assign bus.out_addr   = rd_ptr_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.err_wr     = err_wr_q;
endmodule

// File: doc/mat_mult_1632_mem.md
# mat_mult_1632_mem

Memory responder and host bridge for the 16x49 · 49x32 matrix multiplier. Holds operand banks A (16x49) and B (49x32) and result bank C (16x32). Serves the multiplier's zero-latency read ports and captures its C write strobes. Around that it provides a host load port, a one-cycle start launch, and a valid/ready drain stream that returns C to the host after the multiplier's `done` pulse.

## Interface
- `A_DEPTH`, default 784: A words, row-major, addr = i*49+k.
- `B_DEPTH`, default 1568: B words, row-major, addr = k*32+j.
- `C_DEPTH`, default 512: C words, addr = i*32+j.

Ports:
- `clk` in 1: clock. Rising edge only.
- `reset` in 1: asynchronous, active-high.
- `host_we` in 1: host write strobe.
- `host_sel` in 1: 0 = bank A, 1 = bank B.
- `host_addr` in 11: host word address.
- `host_wdata` in 16 signed: host write data.
- `host_go` in 1: launch request.
- `mult_start` out 1: one-cycle start pulse to the multiplier.
- `addr_a` in 10: multiplier A read address.
- `data_a` out 16 signed: A read data.
- `addr_b` in 11: multiplier B read address.
- `data_b` out 16 signed: B read data.
- `addr_c` in 9: multiplier C write address.
- `data_c` in 32 signed: multiplier C write data.
- `we_c` in 1: C write strobe.
- `mult_done` in 1: multiplier done pulse.
- `out_valid` out 1: drain word valid.
- `out_ready` in 1: host accepts the drain word.
- `out_data` out 32 signed: C word.
- `out_addr` out 9: index of `out_data` in C.
- `out_last` out 1: final drain word.
- `busy` out 1: high in every state except IDLE.
- `err_cnt` out 1: sticky, C write count mismatch.
- `err_wr` out 1: sticky, host write rejected.

## Operation
FSM states: IDLE, BUSY, DRAIN.

- **IDLE**
  - `host_we` writes `host_wdata` to the bank selected by `host_sel` at `host_addr`.
  - The write is dropped silently if `host_addr` ≥ that bank's depth.
  - `host_go` does the following, then moves to BUSY:
    - pulses `mult_start` for exactly one cycle;
    - clears the C write counter, `err_cnt` and `err_wr`.
  - When `host_we` and `host_go` arrive in the same cycle, the write is performed and the launch also occurs.
- **BUSY**
  - `data_a` = A[`addr_a`] and `data_b` = B[`addr_b`], combinational (zero-latency read).
    - The multiplier samples read data on the edge after it updates its address.
    - An address ≥ depth returns 0.
  - `we_c`=1 writes `data_c` into C[`addr_c`] on the rising edge and increments the 10-bit write counter (saturating at 1023).
  - Host writes are ignored and set `err_wr`. `host_go` is ignored.
  - On `mult_done`:
    - go to DRAIN and set the read pointer `rd_ptr` = 0;
    - set `err_cnt` if the counter ≠ `C_DEPTH`.
  - A `we_c` in the same cycle as `mult_done` is still written and counted before the comparison.
- **DRAIN**
  - `out_valid`=1, `out_data` = C[`rd_ptr`], `out_addr` = `rd_ptr`, `out_last` = (`rd_ptr` == `C_DEPTH`-1).
  - On `out_valid` && `out_ready`, `rd_ptr` increments.
  - The transfer with `out_last`=1 returns the FSM to IDLE.
  - While `out_ready`=0, all out_* signals hold.
  - Host writes are ignored and set `err_wr`. `we_c` is ignored.
- `data_a` and `data_b` are driven in every state; the A/B banks are not modified outside IDLE.
- Memory arrays are not reset; contents survive `reset`.

## Timing
- Reset values:
  - `mult_start`, `out_valid`, `out_last`, `busy`, `err_cnt`, `err_wr` = 0;
  - `out_data` and `out_addr` read C[0] and 0;
  - FSM = IDLE, `rd_ptr` = 0, counter = 0.
- Reset asserted mid-BUSY or mid-DRAIN: next state is IDLE immediately. Any partial drain is abandoned, and no `out_last` is issued.
- `mult_start` is registered: it is high the cycle after `host_go` is sampled in IDLE. `busy` rises in the same cycle.
- Host write latency is 1 cycle: the word is readable on `data_a`/`data_b` the cycle after the write edge.
- C write: a word written at edge N is readable in DRAIN from edge N+1.
- DRAIN:
  - `out_valid` is high the cycle after `mult_done` is sampled;
  - one word transfers per cycle under continuous `out_ready`, so 512 cycles minimum;
  - `out_valid` drops the cycle after the last transfer.
- `mult_done` outside BUSY is ignored.

## Test plan
- Load all A words = 1 and all B words = 2, then `host_go` with a real multiplier attached.
  - Required: exactly one `mult_start` pulse.
  - Required: 512 C words, each equal to 98, with `out_addr` 0..511.
  - Required: `out_last` only on index 511, `err_cnt`=0, and FSM back in IDLE.
- A = identity-padded pattern (A[i][k] = (k==i)), B[k][j] = k*32+j.
  - Required: C[i][j] = i*32+j for all i, j.
- Drain with `out_ready` toggled 1,0,0,1 repeating.
  - Required: no word skipped or duplicated; out_* stable whenever `out_ready`=0.
- Host write during BUSY.
  - Required: `err_wr`=1; A/B contents unchanged, verified by the next run's results.
- Inject `mult_done` after only 100 `we_c` pulses.
  - Required: `err_cnt`=1 and the drain still emits 512 words.
- Assert `reset` at drain index 200, then release.
  - Required: `out_valid`=0, `busy`=0.
  - Required: a fresh `host_go` without reloading reproduces the first scenario's results (memory retained).
